// File: rtl/lmdpl_mask_seq_pkg.sv
// Shared types and defaults for the LMDPL mask sequencer.
package lmdpl_mask_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    EVAL,
    DONE
  } phase_t;

  localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'h1;

  // The phase counter only ever holds values up to max_cyc-1.
  function automatic int cnt_width(input int max_cyc);
    return (max_cyc < 2) ? 1 : $clog2(max_cyc);
  endfunction

endpackage

// File: rtl/lmdpl_mask_seq_if.sv
// Handshake, reseed and mask/phase bundle between the sequencer and its users.
interface lmdpl_mask_seq_if #(
  parameter int LFSR_W  = 32,
  parameter int N_GATES = 4
);

  logic                start;
  logic                ready;
  logic                reseed;
  logic [LFSR_W-1:0]   seed_val;
  logic [N_GATES-1:0]  m_in0;
  logic [N_GATES-1:0]  m_in1;
  logic [N_GATES-1:0]  m_out;
  logic                precharge;
  logic                eval;
  logic                done;

  modport master (
    output start, reseed, seed_val,
    input  ready, m_in0, m_in1, m_out, precharge, eval, done
  );

  modport slave (
    input  start, reseed, seed_val,
    output ready, m_in0, m_in1, m_out, precharge, eval, done
  );

endinterface

// File: rtl/lmdpl_mask_seq_lfsr.sv
// Free-running Fibonacci LFSR with reseed port and an all-zero lockup guard.
module lmdpl_lfsr
  import lmdpl_mask_seq_pkg::*;
#(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reseed,
  input  logic [LFSR_W-1:0] seed_val,
  output logic [LFSR_W-1:0] q
);

  logic fb;

  assign fb = ^(q & TAPS);

  // Reseed takes priority over the zero guard; a zero reseed value falls back to SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (reseed) begin
      q <= (seed_val == '0) ? SEED : seed_val;
    end else if (q == '0) begin
      q <= SEED;
    end else begin
      q <= {q[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/lmdpl_mask_seq.sv
// Mask sequencer: hands a fresh mask triple per gate to each operation and
// sequences the precharge/evaluate phases so masks only move during precharge.
module lmdpl_mask_seq
  import lmdpl_mask_seq_pkg::*;
#(
  parameter int                LFSR_W   = 32,
  parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(DEFAULT_SEED),
  parameter int                N_GATES  = 4,
  parameter int                PRE_CYC  = 2,
  parameter int                EVAL_CYC = 2
) (
  input logic              clk,
  input logic              rst_n,
  lmdpl_mask_seq_if.slave  bus
);

  localparam int CNT_W = cnt_width((PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC);

  logic [LFSR_W-1:0]  lfsr_q;
  phase_t             state;
  phase_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               load_masks;
  logic [N_GATES-1:0] m_in0_q;
  logic [N_GATES-1:0] m_in1_q;
  logic [N_GATES-1:0] m_out_q;
  logic               ready_q;
  logic               precharge_q;
  logic               eval_q;
  logic               done_q;

  lmdpl_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .reseed   (bus.reseed),
    .seed_val (bus.seed_val),
    .q        (lfsr_q)
  );

  // Start is only honoured in IDLE and DONE, which are exactly the ready states.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_masks = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = PRE;
          cnt_next   = CNT_W'(PRE_CYC - 1);
          load_masks = 1'b1;
        end
      end
      PRE: begin
        if (cnt == '0) begin
          state_next = EVAL;
          cnt_next   = CNT_W'(EVAL_CYC - 1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      EVAL: begin
        if (cnt == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.start) begin
          state_next = PRE;
          cnt_next   = CNT_W'(PRE_CYC - 1);
          load_masks = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Phase outputs are registered from the next state so nothing combinational reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ready_q     <= 1'b1;
      precharge_q <= 1'b0;
      eval_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      ready_q     <= (state_next == IDLE) || (state_next == DONE);
      precharge_q <= (state_next == PRE);
      eval_q      <= (state_next == EVAL);
      done_q      <= (state_next == DONE);
    end
  end

  // Masks take the pre-shift LFSR slices on the edge entering PRE and are otherwise frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in0_q <= '0;
      m_in1_q <= '0;
      m_out_q <= '0;
    end else if (load_masks) begin
      m_in0_q <= lfsr_q[N_GATES-1:0];
      m_in1_q <= lfsr_q[2*N_GATES-1:N_GATES];
      m_out_q <= lfsr_q[3*N_GATES-1:2*N_GATES];
    end
  end

  assign bus.ready     = ready_q;
  assign bus.precharge = precharge_q;
  assign bus.eval      = eval_q;
  assign bus.done      = done_q;
  assign bus.m_in0     = m_in0_q;
  assign bus.m_in1     = m_in1_q;
  assign bus.m_out     = m_out_q;

endmodule

// File: tb/tb_lmdpl_mask_seq.sv
// Self-checking bench for lmdpl_mask_seq: table vectors, hand-written corner
// sequences and a randomized run against an operation-timeline reference model.
module tb_lmdpl_mask_seq;
  import lmdpl_mask_seq_pkg::*;

  localparam int          W    = 32;
  localparam int          N    = 4;
  localparam int          PRE  = 2;
  localparam int          EVAL = 2;
  localparam int          LAT  = PRE + EVAL + 1;
  localparam logic [31:0] TAPS_P = DEFAULT_TAPS;
  localparam logic [31:0] SEED_P = DEFAULT_SEED;

  typedef struct {
    logic        start;
    logic        reseed;
    logic [31:0] seed_val;
    logic        exp_ready;
    logic        exp_pc;
    logic        exp_ev;
    logic        exp_dn;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lmdpl_mask_seq_if #(.LFSR_W(W), .N_GATES(N)) bus ();

  lmdpl_mask_seq #(
    .LFSR_W   (W),
    .TAPS     (TAPS_P),
    .SEED     (SEED_P),
    .N_GATES  (N),
    .PRE_CYC  (PRE),
    .EVAL_CYC (EVAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: LFSR value plus "cycles since the current op was accepted" (0 = idle).
  logic [31:0]  m_lfsr;
  int           m_t;
  logic [N-1:0] m_i0, m_i1, m_o;
  int           accepts;
  int           dones;
  int           errors = 0;
  int           checks = 0;

  function automatic logic [31:0] lfsrNext(input logic [31:0] q);
    if (q == 32'h0) return SEED_P;
    return (q << 1) | 32'($countones(q & TAPS_P) % 2);
  endfunction

  task automatic modelReset();
    m_lfsr = SEED_P;
    m_t    = 0;
    m_i0   = '0;
    m_i1   = '0;
    m_o    = '0;
  endtask

  task automatic modelEdge(input logic st, input logic rs, input logic [31:0] sv);
    logic rdy;
    rdy = (m_t == 0) || (m_t == LAT);
    if (st && rdy) begin
      m_i0 = N'(m_lfsr);
      m_i1 = N'(m_lfsr >> N);
      m_o  = N'(m_lfsr >> (2 * N));
      m_t  = 1;
      accepts++;
    end else if (m_t == LAT) begin
      m_t = 0;
    end else if (m_t > 0) begin
      m_t++;
    end
    if (rs) m_lfsr = (sv == 32'h0) ? SEED_P : sv;
    else    m_lfsr = lfsrNext(m_lfsr);
  endtask

  task automatic applyStimulus(input logic st, input logic rs, input logic [31:0] sv);
    bus.start    = st;
    bus.reseed   = rs;
    bus.seed_val = sv;
    @(posedge clk);
    modelEdge(st, rs, sv);
    #1;
    if (bus.done) dones++;
  endtask

  task automatic checkOutput(input string name);
    logic [3+3*N:0] got, exp;
    logic e_rdy, e_pc, e_ev, e_dn;
    e_rdy = (m_t == 0) || (m_t == LAT);
    e_pc  = (m_t >= 1) && (m_t <= PRE);
    e_ev  = (m_t > PRE) && (m_t <= PRE + EVAL);
    e_dn  = (m_t == LAT);
    got = {bus.ready, bus.precharge, bus.eval, bus.done, bus.m_in0, bus.m_in1, bus.m_out};
    exp = {e_rdy, e_pc, e_ev, e_dn, m_i0, m_i1, m_o};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s outputs: got %h expected %h (rdy,pc,ev,dn,m_in0,m_in1,m_out)", name, got, exp);
    end
    checks++;
    if (dut.lfsr_q !== m_lfsr) begin
      errors++;
      $display("[TB] FAIL %s lfsr: got %h expected %h", name, dut.lfsr_q, m_lfsr);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    vec_t         vecs[6];
    logic [N-1:0] held_i0, held_i1, held_o;
    logic [31:0]  db_next;

    vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};

    bus.start    = 1'b0;
    bus.reseed   = 1'b0;
    bus.seed_val = '0;
    accepts      = 0;
    dones        = 0;
    modelReset();

    // Reset state, observed while reset is held.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold");
    checkValue("reset_lfsr_seed", dut.lfsr_q, SEED_P);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op from idle, including a start that arrives while busy and must be dropped.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].start, vecs[i].reseed, vecs[i].seed_val);
      checkValue($sformatf("vec%0d_phase", i),
                 {28'h0, bus.ready, bus.precharge, bus.eval, bus.done},
                 {28'h0, vecs[i].exp_ready, vecs[i].exp_pc, vecs[i].exp_ev, vecs[i].exp_dn});
      checkOutput($sformatf("vec%0d", i));
    end

    // Zero reseed falls back to SEED.
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkValue("reseed_zero", dut.lfsr_q, SEED_P);
    checkOutput("reseed_zero_model");

    // Back-to-back ops with start held high: DONE must go straight to PRE.
    for (int c = 0; c < 2 * LAT; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("b2b_c%0d", c));
      if (c == LAT) checkValue("b2b_no_idle", {31'h0, bus.precharge}, 32'h1);
    end
    for (int c = 0; c < LAT; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("b2b_drain_c%0d", c));
    end

    // Reseed during EVAL: current masks untouched, next op uses DEADBEEF-derived slices.
    applyStimulus(1'b1, 1'b0, 32'h0);
    held_i0 = m_i0;
    held_i1 = m_i1;
    held_o  = m_o;
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);
    checkValue("reseed_eval_lfsr", dut.lfsr_q, 32'hDEADBEEF);
    checkValue("reseed_eval_masks_held", {20'h0, bus.m_in0, bus.m_in1, bus.m_out},
               {20'h0, held_i0, held_i1, held_o});
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("reseed_eval_done");
    db_next = lfsrNext(32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkValue("reseed_next_op_masks", {20'h0, bus.m_in0, bus.m_in1, bus.m_out},
               {20'h0, db_next[3:0], db_next[7:4], db_next[11:8]});
    checkOutput("reseed_next_op_model");
    for (int c = 0; c < LAT; c++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("reseed_drain");

    // Asynchronous reset in the middle of EVAL.
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkValue("pre_reset_in_eval", {31'h0, bus.eval}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    checkValue("async_reset_lfsr", dut.lfsr_q, SEED_P);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("post_reset_c1");
    for (int c = 2; c <= LAT; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("post_reset_c%0d", c));
    end
    checkValue("post_reset_done_at_5", {31'h0, bus.done}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Randomized run with random starts and reseeds.
    accepts = 0;
    dones   = 0;
    for (int c = 0; c < 10000; c++) begin
      logic        st, rs;
      logic [31:0] sv;
      st = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 19) == 0);
      sv = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      applyStimulus(st, rs, sv);
      checkOutput($sformatf("rand_c%0d", c));
      checks++;
      if (bus.precharge && bus.eval) begin
        errors++;
        $display("[TB] FAIL rand_phase_overlap c%0d: got pc=1 ev=1 expected not both", c);
      end
    end
    for (int c = 0; c < LAT + 1; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("rand_drain_c%0d", c));
    end
    checkValue("rand_done_count", 32'(dones), 32'(accepts));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
